// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA timing / test-pattern generator:
//   - mode_e      : pattern selector encoding (bars, solid, checker, gradient)
//   - DEF_*       : 640x480@60 timing defaults used as parameter defaults
//   - chan_on_t   : per-channel on/off bits produced by the colour table
//   - colour_decode() : 3-bit table colour -> channel on/off bits
//   - cnt_width()     : counter width able to hold the total and the bits the
//                       pattern logic slices out of the counters
// -----------------------------------------------------------------------------
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_SOLID = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_GRAD  = 2'd3
    } mode_e;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } chan_on_t;

    // Table colour c: red follows ~c[1], green ~c[2], blue ~c[0], which gives
    // white, yellow, cyan, green, magenta, red, blue, black for c = 0..7.
    function automatic chan_on_t colour_decode(input logic [2:0] c);
        chan_on_t o;
        o.r = ~c[1];
        o.g = ~c[2];
        o.b = ~c[0];
        return o;
    endfunction

    // The counters must hold 0..total (sync-end compare may equal the total),
    // and must be wide enough for the gradient (CW bits) and checker
    // (bit chk) slices.
    function automatic int cnt_width(input int total, input int cw, input int chk);
        int w;
        w = $clog2(total + 1);
        if (w < cw) w = cw;
        if (w < chk + 1) w = chk + 1;
        return w;
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// vga_pattern_gen_if
// Bundles the pattern generator's user/pin-side signals.
//   key_en      : single-cycle request to step to the next pattern
//   red/green/blue : CW-bit colour channels
//   hysy/vysy   : horizontal / vertical sync
//   de          : data enable (visible area)
//   mode        : currently displayed pattern
//   frame_start : one-cycle pulse with the first visible pixel of a frame
// Modports: master = the generator, slave = the consumer/driver of key_en.
// -----------------------------------------------------------------------------
interface vga_pattern_gen_if #(
    parameter int unsigned CW = 4
);
    logic          key_en;
    logic [CW-1:0] red;
    logic [CW-1:0] green;
    logic [CW-1:0] blue;
    logic          hysy;
    logic          vysy;
    logic          de;
    logic [1:0]    mode;
    logic          frame_start;

    modport master (
        input  key_en,
        output red, green, blue, hysy, vysy, de, mode, frame_start
    );

    modport slave (
        output key_en,
        input  red, green, blue, hysy, vysy, de, mode, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Free-running horizontal/vertical counters with sync and visible-area decode.
// Line order is active, front porch, sync, back porch (same for frames).
// Ports:
//   s_clk, s_rst   : pixel clock, synchronous active-high reset
//   h_cnt, v_cnt   : current counter position (unregistered view of state)
//   hysy_int/vysy_int : combinational sync levels for the current position
//   de_int         : current position is inside the visible area
//   line_wrap      : h_cnt is on the last clock of a line
//   frame_wrap     : last clock of the last line of a frame
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned HW       = 11,
    parameter int unsigned VW       = 11
) (
    input  logic          s_clk,
    input  logic          s_rst,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          hysy_int,
    output logic          vysy_int,
    output logic          de_int,
    output logic          line_wrap,
    output logic          frame_wrap
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_END    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_END    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;

    assign line_wrap  = (h_cnt_q == H_LAST);
    assign frame_wrap = line_wrap && (v_cnt_q == V_LAST);

    // v_cnt only moves on the last clock of a line, so vysy changes together
    // with the h_cnt wrap.
    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (line_wrap) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt    = h_cnt_q;
    assign v_cnt    = v_cnt_q;
    assign hysy_int = ((h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    assign vysy_int = ((v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    assign de_int   = (h_cnt_q < H_VIS_END) && (v_cnt_q < V_VIS_END);

endmodule

// File: rtl/vga_pattern_gen.sv
// -----------------------------------------------------------------------------
// vga_pattern_gen
// VGA timing and test-pattern generator. Four patterns (colour bars, solid
// colour cycling per frame, checkerboard, gradient) are stepped by key_en;
// a request is held pending and applied only at the frame wrap, so the
// pattern never changes mid-frame. All pin outputs are registered one clock
// after the counter state that produced them.
// Ports:
//   s_clk, s_rst : pixel clock, synchronous active-high reset
//   vif          : vga_pattern_gen_if.master (key_en in; RGB, syncs, de,
//                  mode, frame_start out)
// Build option: define VGA_BORDER_EN to force the outermost visible pixels
// (first/last column and row) to white in every pattern.
// -----------------------------------------------------------------------------
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned CW       = 4,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned CHK_LOG2 = 5
) (
    input  logic               s_clk,
    input  logic               s_rst,
    vga_pattern_gen_if.master  vif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = cnt_width(H_TOTAL, CW, CHK_LOG2);
    localparam int unsigned VW      = cnt_width(V_TOTAL, CW, CHK_LOG2);

    // Bar width in pixels; the bar position is tracked with a small counter
    // rather than dividing h_cnt.
    localparam int unsigned BAR_W = H_ACTIVE / 8;
    localparam int unsigned BPW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [BPW-1:0] BAR_LAST  = BPW'(BAR_W - 1);
    localparam logic [HW-1:0]  H_VIS_END = HW'(H_ACTIVE);

`ifdef VGA_BORDER_EN
    localparam logic [HW-1:0]  H_EDGE_R  = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0]  V_EDGE_B  = VW'(V_ACTIVE - 1);
`endif

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          hysy_int;
    logic          vysy_int;
    logic          de_int;
    logic          line_wrap;
    logic          frame_wrap;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .s_clk      (s_clk),
        .s_rst      (s_rst),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .hysy_int   (hysy_int),
        .vysy_int   (vysy_int),
        .de_int     (de_int),
        .line_wrap  (line_wrap),
        .frame_wrap (frame_wrap)
    );

    mode_e          mode_q, mode_d;
    logic           pending_q, pending_d;
    logic [2:0]     frame_cnt_q, frame_cnt_d;
    logic [BPW-1:0] bar_px_q, bar_px_d;
    logic [2:0]     bar_idx_q, bar_idx_d;

    logic [CW-1:0]  red_q, red_d;
    logic [CW-1:0]  green_q, green_d;
    logic [CW-1:0]  blue_q, blue_d;
    logic           hysy_q, hysy_d;
    logic           vysy_q, vysy_d;
    logic           de_q, de_d;
    logic           frame_start_q, frame_start_d;

    logic [2:0]     pat_c;
    chan_on_t       chan;
    logic [CW-1:0]  red_pat;
    logic [CW-1:0]  green_pat;
    logic [CW-1:0]  blue_pat;

    // A request arriving on the wrap cycle itself is kept as the new pending
    // bit, so it drives the advance at the following wrap.
    always_comb begin
        mode_d      = mode_q;
        pending_d   = pending_q | vif.key_en;
        frame_cnt_d = frame_cnt_q;
        if (frame_wrap) begin
            frame_cnt_d = frame_cnt_q + 3'd1;
            if (pending_q) begin
                mode_d    = mode_e'(mode_q + 2'd1);
                pending_d = vif.key_en;
            end
        end
    end

    // bar_idx_q equals h_cnt / BAR_W for every visible pixel of the line.
    always_comb begin
        bar_px_d  = bar_px_q;
        bar_idx_d = bar_idx_q;
        if (line_wrap) begin
            bar_px_d  = '0;
            bar_idx_d = '0;
        end else if (h_cnt < H_VIS_END) begin
            if (bar_px_q == BAR_LAST) begin
                bar_px_d  = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_px_d  = bar_px_q + 1'b1;
            end
        end
    end

    // Pattern mux for the current counter position.
    always_comb begin
        case (mode_q)
            MODE_BARS:  pat_c = bar_idx_q;
            MODE_SOLID: pat_c = frame_cnt_q;
            MODE_CHECK: pat_c = (h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]) ? 3'd0 : 3'd7;
            default:    pat_c = 3'd0;
        endcase
        chan      = colour_decode(pat_c);
        red_pat   = {CW{chan.r}};
        green_pat = {CW{chan.g}};
        blue_pat  = {CW{chan.b}};
        if (mode_q == MODE_GRAD) begin
            red_pat   = h_cnt[CW-1:0];
            green_pat = v_cnt[CW-1:0];
            blue_pat  = '0;
        end
`ifdef VGA_BORDER_EN
        if ((h_cnt == '0) || (h_cnt == H_EDGE_R) || (v_cnt == '0) || (v_cnt == V_EDGE_B)) begin
            red_pat   = '1;
            green_pat = '1;
            blue_pat  = '1;
        end
`endif
    end

    // Output stage inputs; colour is blanked outside the visible area.
    always_comb begin
        red_d         = de_int ? red_pat   : '0;
        green_d       = de_int ? green_pat : '0;
        blue_d        = de_int ? blue_pat  : '0;
        hysy_d        = hysy_int;
        vysy_d        = vysy_int;
        de_d          = de_int;
        frame_start_d = de_int && (h_cnt == '0) && (v_cnt == '0);
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            mode_q        <= MODE_BARS;
            pending_q     <= 1'b0;
            frame_cnt_q   <= '0;
            bar_px_q      <= '0;
            bar_idx_q     <= '0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            hysy_q        <= ~SYNC_POL;
            vysy_q        <= ~SYNC_POL;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            pending_q     <= pending_d;
            frame_cnt_q   <= frame_cnt_d;
            bar_px_q      <= bar_px_d;
            bar_idx_q     <= bar_idx_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            hysy_q        <= hysy_d;
            vysy_q        <= vysy_d;
            de_q          <= de_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vif.red         = red_q;
    assign vif.green       = green_q;
    assign vif.blue        = blue_q;
    assign vif.hysy        = hysy_q;
    assign vif.vysy        = vysy_q;
    assign vif.de          = de_q;
    assign vif.mode        = mode_q;
    assign vif.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_pattern_gen
// Small-timing bench (H 16/2/3/3, V 8/1/2/1, CW=4, CHK_LOG2=1, active-low
// sync). The reference model works from the absolute cycle index since reset:
// position, frame number and displayed pattern are derived arithmetically,
// and every registered output is compared each clock. Per-frame tallies of
// de, frame_start and sync-low clocks are also checked.
// -----------------------------------------------------------------------------
module tb_vga_pattern_gen;

    localparam int CW  = 4;
    localparam int HA  = 16;
    localparam int HF  = 2;
    localparam int HS  = 3;
    localparam int HB  = 3;
    localparam int VA  = 8;
    localparam int VF  = 1;
    localparam int VS  = 2;
    localparam int VB  = 1;
    localparam int CHK = 1;
    localparam int HT  = HA + HF + HS + HB;
    localparam int VT  = VA + VF + VS + VB;
    localparam int FT  = HT * VT;

    logic s_clk = 1'b0;
    logic s_rst = 1'b1;

    vga_pattern_gen_if #(.CW(CW)) vif ();

    vga_pattern_gen #(
        .CW       (CW),
        .H_ACTIVE (HA),
        .H_FP     (HF),
        .H_SYNC   (HS),
        .H_BP     (HB),
        .V_ACTIVE (VA),
        .V_FP     (VF),
        .V_SYNC   (VS),
        .V_BP     (VB),
        .SYNC_POL (1'b0),
        .CHK_LOG2 (CHK)
    ) dut (
        .s_clk (s_clk),
        .s_rst (s_rst),
        .vif   (vif)
    );

    always #5 s_clk = ~s_clk;

    int checks   = 0;
    int failures = 0;

    // Model state: cycle index since reset, displayed pattern, pending request.
    int k;
    int m_mode;
    bit m_pend;
    int de_cnt, fs_cnt, hs_cnt, vs_cnt;

    logic [11:0] colours [8];

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    function automatic logic [11:0] expPixel(input int h, input int v, input int mode, input int frame);
        logic [3:0] hr;
        logic [3:0] vg;
        if (!(h < HA && v < VA)) return 12'h000;
`ifdef VGA_BORDER_EN
        if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) return 12'hFFF;
`endif
        case (mode)
            0: return colours[h / (HA / 8)];
            1: return colours[frame % 8];
            2: return ((((h >> CHK) + (v >> CHK)) % 2) == 1) ? 12'hFFF : 12'h000;
            default: begin
                hr = 4'(h % 16);
                vg = 4'(v % 16);
                return {hr, vg, 4'h0};
            end
        endcase
    endfunction

    // Directed pulses: mid frame 0; twice in frame 1; mid frame 2; mid frame 3
    // plus one on the frame-3 wrap cycle. Random pulses from frame 6 on.
    function automatic bit keyFor(input int kk);
        if (kk == 100 || kk == 300 || kk == 400 || kk == 700 || kk == 900 || kk == 4 * FT - 1)
            return 1'b1;
        if (kk >= 6 * FT)
            return ($urandom_range(0, 299) == 0);
        return 1'b0;
    endfunction

    task automatic checkOutput(input bit key);
        int h, v, f;
        h = k % HT;
        v = (k / HT) % VT;
        f = k / FT;
        checkVal("rgb", {20'h0, vif.red, vif.green, vif.blue}, {20'h0, expPixel(h, v, m_mode, f)});
        checkVal("hysy", {31'h0, vif.hysy}, (h >= HA + HF && h < HA + HF + HS) ? 0 : 1);
        checkVal("vysy", {31'h0, vif.vysy}, (v >= VA + VF && v < VA + VF + VS) ? 0 : 1);
        checkVal("de", {31'h0, vif.de}, (h < HA && v < VA) ? 1 : 0);
        checkVal("frame_start", {31'h0, vif.frame_start}, (h == 0 && v == 0) ? 1 : 0);

        // Pattern change bookkeeping for the clock just taken.
        if ((k % FT) == FT - 1 && m_pend) begin
            m_mode = (m_mode + 1) % 4;
            m_pend = key;
        end else begin
            m_pend = m_pend | key;
        end
        checkVal("mode", {30'h0, vif.mode}, m_mode);

        de_cnt += int'(vif.de);
        fs_cnt += int'(vif.frame_start);
        hs_cnt += int'(!vif.hysy);
        vs_cnt += int'(!vif.vysy);
        if ((k % FT) == FT - 1) begin
            checkVal("de_per_frame", de_cnt, HA * VA);
            checkVal("fs_per_frame", fs_cnt, 1);
            checkVal("hsync_per_frame", hs_cnt, HS * VT);
            checkVal("vsync_per_frame", vs_cnt, VS * HT);
            de_cnt = 0;
            fs_cnt = 0;
            hs_cnt = 0;
            vs_cnt = 0;
        end
    endtask

    task automatic applyStimulus(input int ncycles);
        bit key;
        for (int i = 0; i < ncycles; i++) begin
            key = keyFor(k);
            vif.key_en = key;
            @(posedge s_clk);
            #1;
            checkOutput(key);
            k++;
        end
        vif.key_en = 1'b0;
    endtask

    task automatic doReset();
        s_rst      = 1'b1;
        vif.key_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge s_clk);
            #1;
            checkVal("rst_rgb", {20'h0, vif.red, vif.green, vif.blue}, 0);
            checkVal("rst_hysy", {31'h0, vif.hysy}, 1);
            checkVal("rst_vysy", {31'h0, vif.vysy}, 1);
            checkVal("rst_de", {31'h0, vif.de}, 0);
            checkVal("rst_fs", {31'h0, vif.frame_start}, 0);
            checkVal("rst_mode", {30'h0, vif.mode}, 0);
        end
        s_rst  = 1'b0;
        k      = 0;
        m_mode = 0;
        m_pend = 1'b0;
        de_cnt = 0;
        fs_cnt = 0;
        hs_cnt = 0;
        vs_cnt = 0;
    endtask

    initial begin
        colours[0] = 12'hFFF;
        colours[1] = 12'hFF0;
        colours[2] = 12'h0FF;
        colours[3] = 12'h0F0;
        colours[4] = 12'hF0F;
        colours[5] = 12'hF00;
        colours[6] = 12'h00F;
        colours[7] = 12'h000;
        k          = 0;
        vif.key_en = 1'b0;

        $display("[TB] reset and 14 frames of pattern stepping");
        doReset();
        applyStimulus(14 * FT);

        $display("[TB] reset in the middle of a frame");
        applyStimulus(100);
        doReset();
        applyStimulus(2 * FT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Parametrised VGA timing and test-pattern generator. Configurable timing, per-channel colour depth, and four selectable patterns. key_en pulses step through the patterns, and each change takes effect at a frame boundary. The block sits between the pixel-clock domain and the DAC/pin drivers, and is the next-generation replacement for the fixed 1-bit vga_ctrl.

Parameters:
CW, 4, bits per colour channel (1..8)
H_ACTIVE, 640, visible pixels per line (multiple of 8)
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines (multiple of 2^CHK_LOG2)
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
SYNC_POL, 0, active level of hysy/vysy (0 = active-low)
CHK_LOG2, 5, checkerboard square size = 2^CHK_LOG2 pixels

Ports:
s_clk  in  1  pixel clock
s_rst  in  1  synchronous reset, active-high
key_en  in  1  single-cycle pulse; request next pattern
red  out  CW  red channel
green  out  CW  green channel
blue  out  CW  blue channel
hysy  out  1  horizontal sync
vysy  out  1  vertical sync
de  out  1  data enable, high in the visible area
mode  out  2  current pattern
frame_start  out  1  one-cycle pulse aligned with the first visible pixel (h=0, v=0)

Behaviour:
- Reset (s_rst sampled high): h_cnt=0, v_cnt=0, mode=0, pending=0, frame counter=0; red/green/blue=0, de=0, frame_start=0, hysy=vysy=~SYNC_POL. Reset mid-frame restarts at h=0, v=0 on the next cycle.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counters:
  - h_cnt counts 0..H_TOTAL-1, then wraps to 0.
  - v_cnt increments when h_cnt wraps, and itself wraps at V_TOTAL-1.
- Line/frame order: active, front porch, sync, back porch.
- Sync decode:
  - hysy = SYNC_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL.
  - vysy uses the same rule on v_cnt; it changes together with h_cnt wrap.
- de_int = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Latency: every output is registered, 1 cycle after the counter state that produced it. RGB is forced to 0 when de_int=0.
- Patterns (mode). Table colour c[2:0] maps to r={CW{~c[1]}}, g={CW{~c[2]}}, b={CW{~c[0]}}.
  - 0 colour bars: c = bar index 0..7, bar width H_ACTIVE/8. Uses a bar counter, no divider. Order: white, yellow, cyan, green, magenta, red, blue, black.
  - 1 solid: c = 3-bit frame counter, incremented at each v_cnt wrap; wraps 7->0.
  - 2 checker: white if h_cnt[CHK_LOG2]^v_cnt[CHK_LOG2], else black.
  - 3 gradient: red = h_cnt[CW-1:0], green = v_cnt[CW-1:0], blue = 0.
- Mode switching:
  - key_en=1 sets pending. Extra pulses while pending is set are ignored.
  - At frame wrap (h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1) with pending=1: mode <= mode+1 (3 wraps to 0), pending cleared.
  - key_en in that same wrap cycle is not lost: pending stays 1, and the next advance happens at the following wrap.
  - A mode change never occurs mid-frame.
- frame_start: high exactly one cycle per frame, coincident with the first de=1 cycle.

Optional Feature:
VGA_BORDER_EN
- Defined: visible pixels with h=0, h=H_ACTIVE-1, v=0 or v=V_ACTIVE-1 are forced to white (all channel bits 1) in every mode. Same latency as normal pixels.
- Undefined: no border logic; pattern pixels pass unchanged.

Decomposition:
- Package vga_pkg:
  - mode encoding constants (MODE_BARS=0, MODE_SOLID=1, MODE_CHECK=2, MODE_GRAD=3)
  - 640x480@60 timing defaults
  - colour-table decode function
- Sub-module vga_timing_gen: h/v counters, sync decode, de_int, frame-wrap strobe, and h/v positions to the parent.
- The parent holds mode/pending control, the bar counter, the pattern mux and the output registers.

Test Plan:
1. Small timing (H 16/2/3/3, V 8/1/2/1, SYNC_POL=0), 2 frames:
   - hysy low for exactly 3 clocks every 24; vysy low for exactly 48 clocks every 288.
   - de high for 16x8 = 128 cycles per frame.
   - frame_start once per frame.
2. Reset:
   - During reset: all RGB=0, hysy=vysy=1, de=0, mode=0.
   - First de=1 occurs 1 cycle after counters reach (0,0).
3. Mode 0 bars, H_ACTIVE=16, CW=4: each visible line outputs 2 pixels each of RGB values FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
4. key_en pulse mid-frame:
   - mode stays 0 until the frame wrap, then reads 1.
   - Solid colour index is 0,1,2... on successive frames.
   - Two pulses in one frame advance mode by only 1.
5. Modes 2 and 3, CHK_LOG2=1: checker flips every 2 pixels/lines; gradient red = h (0..15), green = v.
6. key_en asserted on the frame-wrap cycle while pending=1: mode advances once at that wrap and once again at the next wrap. With VGA_BORDER_EN defined, edge pixels are FFF in every mode.
